// File: rtl/wave_burst_gen.sv
// Burst sample streamer: a rising edge on wave_req reads burst_len samples from the
// selected channel's ROM region and forwards them to the DAC path. Optional: WAVE_BURST_LOOP_EN.
module wave_burst_gen #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wave_req,
    input  logic [7:0]        wave_sel,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              abort,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic              busy,
    output logic              done,
    output logic              ovr,
    output logic              sel_err
);

    localparam int OFS_W = ADDR_W - 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic               req_d_reg;
    logic [2:0]         sel_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   cnt_reg;
    logic [OFS_W-1:0]   offset_reg;
    logic               ovr_reg;
    logic               sel_err_reg;
    logic               valid_reg;
    logic [DATA_W-1:0]  hold_reg;

    logic               req_edge;
    logic               idle_like;
    logic               sel_ok;
    logic               start_burst;
    logic               start_empty;
    logic               bad_sel;
    logic               in_burst;
    logic               last_rd;
    logic               loop_again;

    assign req_edge    = wave_req & ~req_d_reg;
    assign idle_like   = (state_reg == IDLE) || (state_reg == DONE);
    assign in_burst    = (state_reg == RUN) || (state_reg == DRAIN);
    assign sel_ok      = (wave_sel < 8'd8);
    assign start_burst = req_edge & idle_like & sel_ok & (burst_len != '0);
    assign start_empty = req_edge & idle_like & sel_ok & (burst_len == '0);
    assign bad_sel     = req_edge & idle_like & ~sel_ok;
    assign last_rd     = (state_reg == RUN) && (cnt_reg == (len_reg - LEN_W'(1)));

`ifdef WAVE_BURST_LOOP_EN
    // Request still held at the final read: replay the burst with no gap.
    assign loop_again = last_rd & wave_req;
`else
    assign loop_again = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start_burst) begin
                    state_next = RUN;
                end else if (start_empty) begin
                    state_next = DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_rd && !loop_again) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = abort ? IDLE : DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rom_rd = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_reg)
            RUN: begin
                rom_rd = 1'b1;
                busy   = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d_reg   <= 1'b0;
            sel_reg     <= '0;
            len_reg     <= '0;
            cnt_reg     <= '0;
            offset_reg  <= '0;
            ovr_reg     <= 1'b0;
            sel_err_reg <= 1'b0;
            valid_reg   <= 1'b0;
            hold_reg    <= '0;
        end else begin
            req_d_reg   <= wave_req;
            ovr_reg     <= req_edge & in_burst;
            sel_err_reg <= bad_sel;
            // An abort cancels the read issued in the same cycle.
            valid_reg   <= rom_rd & ~abort;
            if (valid_reg) begin
                hold_reg <= rom_data;
            end
            if (start_burst) begin
                sel_reg    <= wave_sel[2:0];
                len_reg    <= burst_len;
                cnt_reg    <= '0;
                offset_reg <= '0;
            end else if (state_reg == RUN) begin
                if (loop_again) begin
                    cnt_reg    <= '0;
                    offset_reg <= '0;
                end else begin
                    cnt_reg    <= cnt_reg + LEN_W'(1);
                    offset_reg <= offset_reg + OFS_W'(1);
                end
            end
        end
    end

    // ROM data arrives in the cycle after the read, aligned with the valid strobe.
    assign dac_data  = valid_reg ? rom_data : hold_reg;
    assign dac_valid = valid_reg;
    assign rom_addr  = {sel_reg, offset_reg};
    assign ovr       = ovr_reg;
    assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_wave_burst_gen.sv
// Bench for wave_burst_gen: timeline model of expected outputs per cycle plus
// directed bursts with literal expectations.
module tb_wave_burst_gen;

    localparam int N = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wave_req = 1'b0;
    logic [7:0]  wave_sel = 8'd0;
    logic [9:0]  burst_len = 10'd0;
    logic        abort = 1'b0;
    logic        rom_rd;
    logic [9:0]  rom_addr;
    logic [11:0] rom_data = 12'd0;
    logic [11:0] dac_data;
    logic        dac_valid;
    logic        busy;
    logic        done;
    logic        ovr;
    logic        sel_err;

    wave_burst_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wave_req  (wave_req),
        .wave_sel  (wave_sel),
        .burst_len (burst_len),
        .abort     (abort),
        .rom_rd    (rom_rd),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .dac_data  (dac_data),
        .dac_valid (dac_valid),
        .busy      (busy),
        .done      (done),
        .ovr       (ovr),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_valid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] rom [0:1023];
    always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

    // Expected-output timeline indexed by cycle.
    logic exp_rd [0:N-1];
    logic exp_valid [0:N-1];
    logic exp_busy [0:N-1];
    logic exp_done [0:N-1];
    logic exp_ovr [0:N-1];
    logic exp_serr [0:N-1];
    int   exp_addr [0:N-1];
    int   exp_data [0:N-1];

    int          mc;
    logic        prev_req = 1'b0;
    int          last_data = 0;
    int          last_rd_cycle = -1;
    int          cur_len = 0;
    int          cur_sel = 0;
    logic        m_edge;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_from(input int s);
        for (int i = s; i < N; i++) begin
            exp_rd[i] = 0; exp_valid[i] = 0; exp_busy[i] = 0; exp_done[i] = 0;
            exp_ovr[i] = 0; exp_serr[i] = 0; exp_addr[i] = 0; exp_data[i] = 0;
        end
    endtask

    // Burst of l reads starting at cycle s; samples trail reads by one cycle.
    task automatic schedule(input int s, input int l, input int sel);
        for (int k = 0; k < l; k++) begin
            exp_rd[s+k]      = 1;
            exp_addr[s+k]    = sel * 128 + (k % 128);
            exp_valid[s+k+1] = 1;
            exp_data[s+k+1]  = rom[sel * 128 + (k % 128)];
        end
        for (int k = 0; k <= l; k++) exp_busy[s+k] = 1;
        exp_done[s+l+1] = 1;
        last_rd_cycle = s + l - 1;
    endtask

    always @(negedge clk) begin
        mc = cyc;
        if (!rst_n) begin
            clear_from(mc);
            prev_req = 0;
            last_data = 0;
            last_rd_cycle = -1;
        end
        chk("rom_rd", rom_rd, exp_rd[mc]);
        if (exp_rd[mc]) chk("rom_addr", rom_addr, exp_addr[mc]);
        chk("dac_valid", dac_valid, exp_valid[mc]);
        if (exp_valid[mc]) begin
            chk("dac_data", dac_data, exp_data[mc]);
            last_data = exp_data[mc];
        end else begin
            chk("dac_hold", dac_data, last_data);
        end
        chk("busy", busy, exp_busy[mc]);
        chk("done", done, exp_done[mc]);
        chk("ovr", ovr, exp_ovr[mc]);
        chk("sel_err", sel_err, exp_serr[mc]);
        if (dac_valid) n_valid++;
        if (rst_n) begin
            m_edge = wave_req && !prev_req;
            if (abort && exp_busy[mc]) begin
                clear_from(mc + 1);
                last_rd_cycle = -1;
            end
`ifdef WAVE_BURST_LOOP_EN
            else if (mc == last_rd_cycle && wave_req) begin
                exp_done[mc+2] = 0;
                schedule(mc + 1, cur_len, cur_sel);
            end
`endif
            if (m_edge) begin
                if (exp_busy[mc]) exp_ovr[mc+1] = 1;
                else if (wave_sel > 8'd7) exp_serr[mc+1] = 1;
                else if (burst_len == 10'd0) exp_done[mc+1] = 1;
                else begin
                    cur_len = int'(burst_len);
                    cur_sel = int'(wave_sel[2:0]);
                    schedule(mc + 1, cur_len, cur_sel);
                end
            end
            prev_req = wave_req;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg(input int n);
        while (cyc < n) tick();
        @(negedge clk);
    endtask

    int t0;
    int nv;

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 12'((i * 37 + 11) & 12'hFFF);
        clear_from(0);

        @(negedge clk);
        chk("rst_addr", rom_addr, 0);
        chk("rst_data", dac_data, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Basic burst: channel 3, four samples.
        wave_sel = 8'd3; burst_len = 10'd4; wave_req = 1'b1; t0 = cyc; nv = n_valid;
        tick(); wave_req = 1'b0;
        @(negedge clk);
        chk("t1_addr_first", rom_addr, 10'h180);
        chk("t1_rd_first", rom_rd, 1);
        at_neg(t0 + 4); chk("t1_addr_last", rom_addr, 10'h183);
        at_neg(t0 + 5); chk("t1_valid_last", dac_valid, 1);
        at_neg(t0 + 6); chk("t1_done", done, 1); chk("t1_busy_off", busy, 0);
        chk("t1_count", n_valid - nv, 4);
        repeat (2) tick();

        // Bad channel.
        wave_sel = 8'd9; wave_req = 1'b1; t0 = cyc;
        tick(); wave_req = 1'b0;
        @(negedge clk);
        chk("t2_sel_err", sel_err, 1); chk("t2_busy", busy, 0); chk("t2_rd", rom_rd, 0);
        at_neg(t0 + 3); chk("t2_no_rd", rom_rd, 0);
        tick();

        // Region wrap: channel 1, 130 samples.
        wave_sel = 8'd1; burst_len = 10'd130; wave_req = 1'b1; t0 = cyc; nv = n_valid;
        tick(); wave_req = 1'b0;
        at_neg(t0 + 128); chk("t3_addr_top", rom_addr, 10'h0FF);
        at_neg(t0 + 129); chk("t3_addr_wrap", rom_addr, 10'h080);
        at_neg(t0 + 130); chk("t3_addr_end", rom_addr, 10'h081);
        at_neg(t0 + 132); chk("t3_done", done, 1); chk("t3_count", n_valid - nv, 130);
        tick();

        // Overrun: second edge at the third cycle of a len 8 burst.
        wave_sel = 8'd2; burst_len = 10'd8; wave_req = 1'b1; t0 = cyc; nv = n_valid;
        tick(); wave_req = 1'b0;
        tick();
        tick(); wave_req = 1'b1;
        tick(); wave_req = 1'b0;
        @(negedge clk); chk("t4_ovr", ovr, 1);
        at_neg(t0 + 5); chk("t4_ovr_pulse", ovr, 0);
        at_neg(t0 + 10); chk("t4_done", done, 1); chk("t4_count", n_valid - nv, 8);
        tick();

        // Abort on the second sample of a len 6 burst.
        wave_sel = 8'd5; burst_len = 10'd6; wave_req = 1'b1; t0 = cyc; nv = n_valid;
        tick(); wave_req = 1'b0;
        tick();
        tick(); abort = 1'b1;
        tick(); abort = 1'b0;
        @(negedge clk); chk("t5_busy_off", busy, 0); chk("t5_valid_off", dac_valid, 0);
        at_neg(t0 + 8); chk("t5_no_done", done, 0); chk("t5_count", n_valid - nv, 2);
        tick();

        // Zero length: done only.
        wave_sel = 8'd4; burst_len = 10'd0; wave_req = 1'b1;
        tick(); wave_req = 1'b0;
        @(negedge clk); chk("t6_done", done, 1); chk("t6_rd", rom_rd, 0); chk("t6_busy", busy, 0);
        repeat (2) tick();

        // Back-to-back: next edge lands in DONE.
        wave_sel = 8'd6; burst_len = 10'd2; wave_req = 1'b1; t0 = cyc;
        tick(); wave_req = 1'b0;
        at_neg(t0 + 3);
        tick(); wave_sel = 8'd7; burst_len = 10'd3; wave_req = 1'b1;
        @(negedge clk); chk("t7_done1", done, 1);
        tick(); wave_req = 1'b0;
        @(negedge clk); chk("t7_rd2", rom_rd, 1); chk("t7_addr2", rom_addr, 10'h380);
        at_neg(t0 + 9); chk("t7_done2", done, 1);
        tick();

        // Asynchronous reset mid-burst.
        wave_sel = 8'd3; burst_len = 10'd10; wave_req = 1'b1; t0 = cyc;
        tick(); wave_req = 1'b0;
        while (cyc < t0 + 4) tick();
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t8_rd", rom_rd, 0); chk("t8_busy", busy, 0); chk("t8_valid", dac_valid, 0);
        chk("t8_data", dac_data, 0); chk("t8_addr", rom_addr, 0); chk("t8_done", done, 0);
        tick(); rst_n = 1'b1;
        repeat (14) tick();

`ifdef WAVE_BURST_LOOP_EN
        // Held request repeats the burst.
        wave_sel = 8'd0; burst_len = 10'd3; wave_req = 1'b1; t0 = cyc; nv = n_valid;
        repeat (7) tick();
        wave_req = 1'b0;
        at_neg(t0 + 10); chk("t9_drain", busy, 1);
        at_neg(t0 + 11); chk("t9_done", done, 1); chk("t9_count", n_valid - nv, 9);
        tick();
`endif

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
